if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch front end of the pipelined MIPS CPU: holds the PC, owns the instruction memory, and drives the IF/ID pipeline register consumed by decode. A word-wide load port lets the bench or boot logic fill memory while the stage is idle. A small run-control FSM starts, stalls, redirects and halts fetch.

## Interface
- IMEM_DEPTH, 256, instruction memory depth in 32-bit words; power of two.
- RESET_PC, 32'h0000_0000, PC value after reset and on start.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- load_we_i  in  1  memory write enable; accepted in any state.
- load_addr_i  in  $clog2(IMEM_DEPTH)  word index to write.
- load_data_i  in  32  word to write.
- start_i  in  1  single-cycle pulse; IDLE → RUN.
- stall_i  in  1  hazard stall from decode; hold PC and IF/ID.
- flush_i  in  1  kill the IF/ID contents; asserted with a redirect.
- branch_taken_i  in  1  redirect to branch_target_i.
- branch_target_i  in  32  branch destination.
- jump_i  in  1  redirect to jump_target_i.
- jump_target_i  in  32  jump destination.
- pc_o  out  32  current fetch PC; reset RESET_PC.
- instr_o  out  32  IF/ID instruction; reset 0.
- pc_plus4_o  out  32  IF/ID PC+4; reset 0.
- valid_o  out  1  IF/ID holds a live instruction; reset 0.
- halted_o  out  1  FSM is in HALT; reset 0.
- fetch_count_o  out  32  instructions fetched; reset 0.
- stall_count_o  out  32  cycles stalled in RUN; reset 0.

## Operation
- The FSM has three states: IDLE, RUN and HALT. Reset forces IDLE.
- IDLE:
  - PC = RESET_PC and valid_o = 0.
  - start_i moves to RUN on the next edge.
- RUN: each edge, first matching rule applies:
  - branch_taken_i → PC = branch_target_i. Branch beats jump because it is the older instruction.
  - jump_i → PC = jump_target_i.
  - stall_i → PC and IF/ID hold.
  - otherwise → IF/ID gets {instr, PC+4, valid=1} and PC = PC+4.
- Redirects win over stall_i.
- On any redirect, IF/ID valid_o goes to 0 and instr_o to 0 when flush_i is high; otherwise IF/ID holds.
- Fetch read:
  - Combinational, using word index pc_o[2 +: $clog2(IMEM_DEPTH)].
  - pc_o[1:0] are ignored.
  - If pc_o ≥ IMEM_DEPTH*4, the fetch returns 32'h0000_0000 (NOP); there is no wrap.
- Halt:
  - A non-stalled fetch of 32'hFFFF_FFFF still loads IF/ID with valid_o = 1.
  - Next state is HALT.
  - In HALT: PC frozen, valid_o = 0 from the next edge, halted_o = 1. Only reset leaves HALT.
- start_i is ignored in RUN and HALT.
- Load port:
  - A write lands on the edge.
  - A same-cycle fetch of the same word returns the old contents.
- Memory contents are not cleared by reset.
- All 32-bit PC arithmetic is modulo 2^32.

## Timing
- PC to IF/ID latency is one cycle: instr_o at edge N+1 is the word at pc_o during cycle N.
- The first valid_o comes one edge after the edge that enters RUN.
- A redirect presented in cycle N:
  - pc_o = target after edge N.
  - The target instruction is in IF/ID after edge N+1.
- stall_i is level-sensitive. Outputs are stable for its whole duration.
- rst_i asserted mid-run clears all outputs immediately (asynchronously) and returns to IDLE. Memory is kept.

## Configuration
- IF_PERF_CNT_EN defined:
  - fetch_count_o increments on every IF/ID load with valid = 1.
  - stall_count_o increments every RUN cycle where stall_i is applied.
  - Both saturate at 32'hFFFF_FFFF.
  - Both clear on reset only.
- IF_PERF_CNT_EN undefined: both outputs are tied to 0 and no counter flops exist.

## Structure
- Shared package cpu_pkg:
  - fetch-state enum {IDLE, RUN, HALT}
  - NOP_INSTR = 32'h0
  - HALT_INSTR = 32'hFFFF_FFFF
  - RESET_PC default
- One sub-module: imem_1r1w. Word array, combinational read port, synchronous write port.
- if_stage contains the FSM, PC, IF/ID register and counters.

## Test plan
- Program load and fetch:
  - Stimulus: load words 0..3 = 1,2,3,HALT_INSTR, then pulse start_i.
  - Response: instr_o = 1,2,3,HALT_INSTR on consecutive cycles with pc_plus4_o = 4,8,12,16. halted_o = 1 the cycle after; valid_o = 0 thereafter.
- Stall:
  - Stimulus: assert stall_i for 3 cycles when pc_o = 8.
  - Response: pc_o stays 8 and instr_o is held. stall_count_o = 3 with IF_PERF_CNT_EN, 0 without.
- Branch vs jump:
  - Stimulus: branch_taken_i and jump_i high together with targets 0x40 and 0x80, flush_i high.
  - Response: pc_o = 0x40 and valid_o = 0 next cycle; the word at 0x40 is in instr_o one cycle later.
- Out-of-range fetch:
  - Stimulus: jump to IMEM_DEPTH*4.
  - Response: instr_o = 0 with valid_o = 1; PC continues incrementing.
- Reset mid-run:
  - Stimulus: assert rst_i between edges while in RUN.
  - Response: pc_o = RESET_PC, valid_o = 0 and counters = 0 immediately, state IDLE. Memory is intact: a restart refetches word 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS front end: fetch FSM states and
// the special instruction encodings recognised by the fetch stage.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR       = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/imem_1r1w.sv
// Instruction memory: word array with a combinational read port and a
// synchronous write port. A same-cycle read of the written word sees old data.
module imem_1r1w #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, run-control FSM, instruction memory and IF/ID
// register. Optional performance counters are built when IF_PERF_CNT_EN is defined.
module if_stage
    import cpu_pkg::*;
#(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          load_we_i,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr_i,
    input  logic [31:0]                   load_data_i,
    input  logic                          start_i,
    input  logic                          stall_i,
    input  logic                          flush_i,
    input  logic                          branch_taken_i,
    input  logic [31:0]                   branch_target_i,
    input  logic                          jump_i,
    input  logic [31:0]                   jump_target_i,
    output logic [31:0]                   pc_o,
    output logic [31:0]                   instr_o,
    output logic [31:0]                   pc_plus4_o,
    output logic                          valid_o,
    output logic                          halted_o,
    output logic [31:0]                   fetch_count_o,
    output logic [31:0]                   stall_count_o
);

    localparam int AW = $clog2(IMEM_DEPTH);

    fetch_state_e state, state_nxt;

    logic [31:0] pc_p0;
    logic [31:0] mem_word;
    logic [31:0] fetch_instr;
    logic        in_range;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_en;

    logic [31:0] instr_p1;
    logic [31:0] pc_plus4_p1;
    logic        vld_p1;

    imem_1r1w #(
        .DEPTH (IMEM_DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk_i),
        .we    (load_we_i),
        .waddr (load_addr_i),
        .wdata (load_data_i),
        .raddr (pc_p0[2 +: AW]),
        .rdata (mem_word)
    );

    // Fetch addresses past the end of memory read as NOP instead of wrapping
    assign in_range    = (pc_p0 >> (AW + 2)) == 32'd0;
    assign fetch_instr = in_range ? mem_word : NOP_INSTR;

    assign redirect    = branch_taken_i | jump_i;
    assign redirect_pc = branch_taken_i ? branch_target_i : jump_target_i;
    assign fetch_en    = (state == RUN) && !redirect && !stall_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = RUN;
            RUN:  if (fetch_en && fetch_instr == HALT_INSTR) state_nxt = HALT;
            HALT: state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: PC update and IF/ID register load
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_p0       <= RESET_PC;
            instr_p1    <= NOP_INSTR;
            pc_plus4_p1 <= 32'd0;
            vld_p1      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    pc_p0  <= RESET_PC;
                    vld_p1 <= 1'b0;
                end
                RUN: begin
                    if (redirect) begin
                        pc_p0 <= redirect_pc;
                        if (flush_i) begin
                            vld_p1   <= 1'b0;
                            instr_p1 <= NOP_INSTR;
                        end
                    end else if (!stall_i) begin
                        instr_p1    <= fetch_instr;
                        pc_plus4_p1 <= pc_p0 + 32'd4;
                        vld_p1      <= 1'b1;
                        pc_p0       <= pc_p0 + 32'd4;
                    end
                end
                HALT: vld_p1 <= 1'b0;
                default: vld_p1 <= 1'b0;
            endcase
        end
    end

    assign pc_o       = pc_p0;
    assign instr_o    = instr_p1;
    assign pc_plus4_o = pc_plus4_p1;
    assign valid_o    = vld_p1;
    assign halted_o   = (state == HALT);

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] stall_cnt;
    logic        stall_applied;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // A stall only counts when it actually holds the stage (redirects override it)
    assign stall_applied = (state == RUN) && !redirect && stall_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (fetch_en)      fetch_cnt <= sat_inc(fetch_cnt);
            if (stall_applied) stall_cnt <= sat_inc(stall_cnt);
        end
    end

    assign fetch_count_o = fetch_cnt;
    assign stall_count_o = stall_cnt;
`else
    assign fetch_count_o = 32'd0;
    assign stall_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expected values are hand-computed.
`timescale 1ns/1ps
module tb_if_stage;

    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [31:0]   load_data = '0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic          br = 1'b0;
    logic [31:0]   br_tgt = '0;
    logic          jmp = 1'b0;
    logic [31:0]   jmp_tgt = '0;
    logic [31:0]   pc, instr, pc_plus4, fetch_count, stall_count;
    logic          valid, halted;

    int errors = 0;
    int checks = 0;

    if_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .load_we_i       (load_we),
        .load_addr_i     (load_addr),
        .load_data_i     (load_data),
        .start_i         (start),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_taken_i  (br),
        .branch_target_i (br_tgt),
        .jump_i          (jmp),
        .jump_target_i   (jmp_tgt),
        .pc_o            (pc),
        .instr_o         (instr),
        .pc_plus4_o      (pc_plus4),
        .valid_o         (valid),
        .halted_o        (halted),
        .fetch_count_o   (fetch_count),
        .stall_count_o   (stall_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int idx, input logic [31:0] data);
        load_we   = 1'b1;
        load_addr = AW'(idx);
        load_data = data;
        step();
        load_we   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) step();
        checks++; if (pc !== 32'h0)   begin errors++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
        checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want %h", instr, 32'h0); end
        checks++; if (valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags: got valid=%b halted=%b want 0 0", valid, halted); end
        checks++; if (pc_plus4 !== 32'h0 || fetch_count !== 32'h0 || stall_count !== 32'h0) begin
            errors++; $display("FAIL reset_cnt: got p4=%h fc=%h sc=%h want 0", pc_plus4, fetch_count, stall_count);
        end
        rst = 1'b0;
        step();
        checks++; if (pc !== 32'h0 || valid !== 1'b0) begin errors++; $display("FAIL idle_hold: got pc=%h valid=%b want 0 0", pc, valid); end
    endtask

    task automatic test_program();
        logic [31:0] exp_i [4];
        exp_i[0] = 32'd1; exp_i[1] = 32'd2; exp_i[2] = 32'd3; exp_i[3] = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) load_word(i, exp_i[i]);
        load_word(16, 32'hAAAA_0040);
        load_word(17, 32'hAAAA_0044);
        load_word(32, 32'hBBBB_0080);
        start_run();
        checks++; if (valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL run_entry: got valid=%b pc=%h want 0 0", valid, pc); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (instr !== exp_i[i] || pc_plus4 !== 32'((i + 1) * 4) || valid !== 1'b1) begin
                errors++;
                $display("FAIL fetch_%0d: got instr=%h p4=%h v=%b want %h %h 1", i, instr, pc_plus4, valid, exp_i[i], 32'((i + 1) * 4));
            end
        end
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_enter: got halted=%b want 1", halted); end
        step();
        checks++; if (valid !== 1'b0 || halted !== 1'b1 || pc !== 32'd16) begin
            errors++; $display("FAIL halt_state: got v=%b h=%b pc=%h want 0 1 10", valid, halted, pc);
        end
        start_run();
        step();
        checks++; if (halted !== 1'b1 || pc !== 32'd16 || valid !== 1'b0) begin
            errors++; $display("FAIL halt_ignore_start: got h=%b pc=%h v=%b want 1 10 0", halted, pc, valid);
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_sc, exp_fc;
`ifdef IF_PERF_CNT_EN
        exp_sc = 32'd3; exp_fc = 32'd3;
`else
        exp_sc = 32'd0; exp_fc = 32'd0;
`endif
        do_reset();
        start_run();
        step();
        step();
        checks++; if (pc !== 32'd8 || instr !== 32'd2) begin errors++; $display("FAIL stall_pre: got pc=%h instr=%h want 8 2", pc, instr); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (pc !== 32'd8 || instr !== 32'd2 || pc_plus4 !== 32'd8 || valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d: got pc=%h instr=%h p4=%h v=%b want 8 2 8 1", i, pc, instr, pc_plus4, valid);
            end
        end
        stall = 1'b0;
        step();
        checks++; if (pc !== 32'd12 || instr !== 32'd3) begin errors++; $display("FAIL stall_release: got pc=%h instr=%h want c 3", pc, instr); end
        checks++; if (stall_count !== exp_sc) begin errors++; $display("FAIL stall_count: got %0d want %0d", stall_count, exp_sc); end
        checks++; if (fetch_count !== exp_fc) begin errors++; $display("FAIL fetch_count: got %0d want %0d", fetch_count, exp_fc); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        start_run();
        step();
        br = 1'b1; br_tgt = 32'h40; jmp = 1'b1; jmp_tgt = 32'h80; flush = 1'b1;
        step();
        br = 1'b0; jmp = 1'b0; flush = 1'b0;
        checks++; if (pc !== 32'h40 || valid !== 1'b0 || instr !== 32'h0) begin
            errors++; $display("FAIL branch_prio: got pc=%h v=%b instr=%h want 40 0 0", pc, valid, instr);
        end
        step();
        checks++; if (instr !== 32'hAAAA_0040 || valid !== 1'b1 || pc_plus4 !== 32'h44 || pc !== 32'h44) begin
            errors++; $display("FAIL branch_target: got instr=%h v=%b p4=%h pc=%h want aaaa0040 1 44 44", instr, valid, pc_plus4, pc);
        end
        jmp = 1'b1; jmp_tgt = 32'h80; flush = 1'b0;
        step();
        jmp = 1'b0;
        checks++; if (pc !== 32'h80 || valid !== 1'b1 || instr !== 32'hAAAA_0040) begin
            errors++; $display("FAIL jump_noflush: got pc=%h v=%b instr=%h want 80 1 aaaa0040", pc, valid, instr);
        end
        step();
        checks++; if (instr !== 32'hBBBB_0080 || pc !== 32'h84) begin
            errors++; $display("FAIL jump_target: got instr=%h pc=%h want bbbb0080 84", instr, pc);
        end
        stall = 1'b1; jmp = 1'b1; jmp_tgt = 32'h44; flush = 1'b1;
        step();
        stall = 1'b0; jmp = 1'b0; flush = 1'b0;
        checks++; if (pc !== 32'h44 || valid !== 1'b0) begin
            errors++; $display("FAIL redirect_over_stall: got pc=%h v=%b want 44 0", pc, valid);
        end
        step();
        checks++; if (instr !== 32'hAAAA_0044 || valid !== 1'b1) begin
            errors++; $display("FAIL redirect_stall_tgt: got instr=%h v=%b want aaaa0044 1", instr, valid);
        end
    endtask

    task automatic test_out_of_range();
        jmp = 1'b1; jmp_tgt = 32'(DEPTH * 4); flush = 1'b1;
        step();
        jmp = 1'b0; flush = 1'b0;
        checks++; if (pc !== 32'h400) begin errors++; $display("FAIL oor_pc: got %h want 400", pc); end
        step();
        checks++; if (instr !== 32'h0 || valid !== 1'b1 || pc !== 32'h404 || pc_plus4 !== 32'h404) begin
            errors++; $display("FAIL oor_fetch: got instr=%h v=%b pc=%h p4=%h want 0 1 404 404", instr, valid, pc, pc_plus4);
        end
        step();
        checks++; if (pc !== 32'h408 || halted !== 1'b0) begin errors++; $display("FAIL oor_continue: got pc=%h h=%b want 408 0", pc, halted); end
    endtask

    task automatic test_reset_mid_run();
        #3;
        rst = 1'b1;
        #1;
        checks++; if (pc !== 32'h0 || valid !== 1'b0 || instr !== 32'h0 || halted !== 1'b0) begin
            errors++; $display("FAIL async_reset: got pc=%h v=%b instr=%h h=%b want 0 0 0 0", pc, valid, instr, halted);
        end
        checks++; if (fetch_count !== 32'h0 || stall_count !== 32'h0 || pc_plus4 !== 32'h0) begin
            errors++; $display("FAIL async_reset_cnt: got fc=%h sc=%h p4=%h want 0", fetch_count, stall_count, pc_plus4);
        end
        step();
        rst = 1'b0;
        step();
        checks++; if (valid !== 1'b0 || pc !== 32'h0) begin errors++; $display("FAIL reset_idle: got v=%b pc=%h want 0 0", valid, pc); end
        start_run();
        step();
        checks++; if (instr !== 32'd1 || valid !== 1'b1 || pc_plus4 !== 32'd4) begin
            errors++; $display("FAIL restart_fetch: got instr=%h v=%b p4=%h want 1 1 4", instr, valid, pc_plus4);
        end
    endtask

    task automatic test_back_to_back_load();
        load_we = 1'b1; load_addr = AW'(1); load_data = 32'h1234_5678;
        step();
        load_we = 1'b0;
        checks++; if (instr !== 32'd2) begin errors++; $display("FAIL load_same_cycle: got %h want 2", instr); end
        jmp = 1'b1; jmp_tgt = 32'h4; flush = 1'b1;
        step();
        jmp = 1'b0; flush = 1'b0;
        step();
        checks++; if (instr !== 32'h1234_5678) begin errors++; $display("FAIL load_new_word: got %h want 12345678", instr); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_stall();
        test_branch_jump();
        test_out_of_range();
        test_reset_mid_run();
        test_back_to_back_load();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
